// File: rtl/dmem_pkg.sv
// Shared constants and helpers for the data-memory responder: MMIO offsets,
// STATUS bit layout, address region type and the byte-enable legality check.
package dmem_pkg;

   localparam logic [3:0] OFF_CYCLE  = 4'h0;
   localparam logic [3:0] OFF_TXDATA = 4'h4;
   localparam logic [3:0] OFF_STATUS = 4'h8;
   localparam logic [3:0] OFF_ERRCLR = 4'hC;

   localparam int ST_FULL  = 0;
   localparam int ST_EMPTY = 1;
   localparam int ST_ERR   = 2;
   localparam int ST_COUNT = 3;

   typedef enum logic [1:0] {
      REG_RAM,
      REG_MMIO,
      REG_UNMAPPED
   } region_e;

   // Byte, aligned halfword or full word only; 0000 means no store.
   function automatic logic we_legal(input logic [3:0] we);
      case (we)
         4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
         4'b0011, 4'b1100, 4'b1111: return 1'b1;
         default:                   return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/dmem_tx_fifo.sv
// Debug-console TX FIFO with a combinational head; a push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_din,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_dout,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == FULL_CNT);
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_dout    = r_mem[r_rd_ptr];
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_din;
   end

   // Depth is a power of two, so pointers wrap by natural overflow.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the single-cycle core: word RAM with byte-lane
// stores, plus an MMIO window holding a cycle counter, TX FIFO and error flag.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter int          FIFO_DEPTH  = 4,
   parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] daddr,
   input  logic [31:0] dwdata,
   input  logic [3:0]  we,
   output logic [31:0] drdata,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        err
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [31:0]   r_ram [DEPTH_WORDS];
   logic [31:0]   r_cycle;
   logic          r_err;

   region_e       w_region;
   logic [AW-1:0] w_widx;
   logic [1:0]    w_off;
   logic          w_wr;
   logic          w_illegal;
   logic          w_push;
   logic          w_pop;
   logic          w_full;
   logic          w_empty;
   logic          w_overflow;
   logic          w_unmapped_wr;
   logic          w_errclr;
   logic [CW-1:0] w_count;
   logic [31:0]   w_count_ext;
   logic [2:0]    w_cnt3;
   logic [31:0]   w_status;
   logic [31:0]   w_merged;
   logic          w_unused_ok;

   always_comb begin
      w_region = REG_UNMAPPED;
      if ({2'b00, daddr[31:2]} < 32'(DEPTH_WORDS))
         w_region = REG_RAM;
      else if (daddr[31:4] == MMIO_BASE[31:4])
         w_region = REG_MMIO;
   end

   assign w_widx        = daddr[AW+1:2];
   assign w_off         = daddr[3:2];
   assign w_illegal     = (we != 4'b0000) && !we_legal(we);
   assign w_wr          = (we != 4'b0000) && we_legal(we);
   assign w_push        = w_wr && (w_region == REG_MMIO) && (w_off == OFF_TXDATA[3:2]) && we[0];
   assign w_pop         = tx_valid && tx_ready;
   assign w_overflow    = w_push && w_full && !w_pop;
   assign w_unmapped_wr = w_wr && (w_region == REG_UNMAPPED);
   assign w_errclr      = w_wr && (w_region == REG_MMIO) && (w_off == OFF_ERRCLR[3:2]);
   assign w_unused_ok   = &{1'b0, daddr[1:0]};

   tx_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_din   (dwdata[7:0]),
      .i_pop   (tx_ready),
      .o_dout  (tx_data),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   assign tx_valid = !w_empty;
   assign err      = r_err;

   // Byte-lane merge: disabled lanes keep the word's current contents.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign w_merged[gi*8 +: 8] = we[gi] ? dwdata[gi*8 +: 8] : r_ram[w_widx][gi*8 +: 8];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (w_wr && (w_region == REG_RAM)) r_ram[w_widx] <= w_merged;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cycle <= 32'h0;
         r_err   <= 1'b0;
      end else begin
         r_cycle <= r_cycle + 32'd1;
         if (w_illegal || w_unmapped_wr || w_overflow)
            r_err <= 1'b1;
         else if (w_errclr)
            r_err <= 1'b0;
      end
   end

   assign w_count_ext = 32'(w_count);
   assign w_cnt3      = (w_count_ext > 32'd7) ? 3'd7 : w_count_ext[2:0];

   always_comb begin
      w_status                   = 32'h0;
      w_status[ST_FULL]          = w_full;
      w_status[ST_EMPTY]         = w_empty;
      w_status[ST_ERR]           = r_err;
      w_status[ST_COUNT +: 3]    = w_cnt3;
   end

   always_comb begin
      drdata = 32'h0;
      case (w_region)
         REG_RAM: drdata = r_ram[w_widx];
         REG_MMIO: begin
            if (w_off == OFF_CYCLE[3:2])       drdata = r_cycle;
            else if (w_off == OFF_STATUS[3:2]) drdata = w_status;
         end
         default: drdata = 32'h0;
      endcase
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus a randomized
// run against a queue/array reference model of the memory map.
module tb_dmem_responder;

   localparam logic [31:0] MB      = 32'hFFFF_0000;
   localparam logic [31:0] A_CYCLE = MB;
   localparam logic [31:0] A_TX    = MB + 32'h4;
   localparam logic [31:0] A_ST    = MB + 32'h8;
   localparam logic [31:0] A_CLR   = MB + 32'hC;
   localparam logic [31:0] A_UNM   = 32'h1000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] daddr;
   logic [31:0] dwdata;
   logic [3:0]  we;
   logic [31:0] drdata;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        err;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [31:0] m_ram [0:1023];
   logic [7:0]  m_q[$];
   bit          m_err;
   logic [31:0] m_cycle;

   dmem_responder #(
      .DEPTH_WORDS (1024),
      .FIFO_DEPTH  (4),
      .MMIO_BASE   (MB)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .daddr    (daddr),
      .dwdata   (dwdata),
      .we       (we),
      .drdata   (drdata),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .err      (err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic bit m_legal(input logic [3:0] w);
      return w inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
   endfunction

   function automatic bit m_is_mmio(input logic [31:0] a);
      return (a >= MB) && (a <= MB + 32'd15);
   endfunction

   function automatic logic [31:0] m_read(input logic [31:0] a);
      int n = m_q.size();
      if (a < 32'h1000) return m_ram[a[11:2]];
      if (m_is_mmio(a)) begin
         if (a[3:2] == 2'd0) return m_cycle;
         if (a[3:2] == 2'd2) return {26'b0, 3'(n > 7 ? 7 : n), m_err, (n == 0), (n == 4)};
      end
      return 32'h0;
   endfunction

   task automatic model_step(input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] w, input logic rdy);
      bit pop  = (m_q.size() > 0) && rdy;
      bit set  = 1'b0;
      bit clr  = 1'b0;
      bit push = 1'b0;
      if (w != 4'h0 && !m_legal(w)) set = 1'b1;
      else if (w != 4'h0) begin
         if (a < 32'h1000) begin
            for (int b = 0; b < 4; b++)
               if (w[b]) m_ram[a[11:2]][b*8 +: 8] = wd[b*8 +: 8];
         end else if (m_is_mmio(a)) begin
            if (a[3:2] == 2'd1 && w[0]) push = 1'b1;
            if (a[3:2] == 2'd3) clr = 1'b1;
         end else set = 1'b1;
      end
      if (push && m_q.size() == 4 && !pop) begin
         set  = 1'b1;
         push = 1'b0;
      end
      if (pop)  void'(m_q.pop_front());
      if (push) m_q.push_back(wd[7:0]);
      if (set) m_err = 1'b1;
      else if (clr) m_err = 1'b0;
      m_cycle = m_cycle + 32'd1;
   endtask

   // One bus cycle: drive at the falling edge, sample pre-edge, step the model.
   task automatic cyc(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] w,
                      input logic rdy, output logic [31:0] rd, output logic v,
                      output logic [7:0] d, output logic e);
      daddr = a; dwdata = wd; we = w; tx_ready = rdy;
      #1;
      rd = drdata; v = tx_valid; d = tx_data; e = err;
      @(posedge clk);
      model_step(a, wd, w, rdy);
      @(negedge clk);
   endtask

   task automatic model_reset();
      m_q.delete();
      m_err   = 1'b0;
      m_cycle = 32'h0;
   endtask

   task automatic apply_reset();
      daddr = 32'h0; dwdata = 32'h0; we = 4'h0; tx_ready = 1'b0;
      #2 reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      logic [31:0] rd; logic v; logic [7:0] d; logic e;
      cyc(A_CYCLE, 32'h0, 4'h0, 1'b0, rd, v, d, e);
      tests_run++;
      if (rd !== 32'h0) begin tests_failed++; $display("FAIL reset_cycle: got %h want %h", rd, 32'h0); end
      tests_run++;
      if (v !== 1'b0) begin tests_failed++; $display("FAIL reset_tx_valid: got %b want 0", v); end
      tests_run++;
      if (e !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b want 0", e); end
      cyc(A_ST, 32'h0, 4'h0, 1'b0, rd, v, d, e);
      tests_run++;
      if (rd !== 32'h2) begin tests_failed++; $display("FAIL reset_status: got %h want %h", rd, 32'h2); end
   endtask

   task automatic test_byte_lanes();
      logic [31:0] rd; logic v; logic [7:0] d; logic e;
      cyc(32'h10, 32'hAABBCCDD, 4'hF, 1'b0, rd, v, d, e);
      cyc(32'h10, 32'h0000_0011, 4'h1, 1'b0, rd, v, d, e);
      cyc(32'h10, 32'h0, 4'h0, 1'b0, rd, v, d, e);
      tests_run++;
      if (rd !== 32'hAABBCC11) begin tests_failed++; $display("FAIL lanes_byte: got %h want %h", rd, 32'hAABBCC11); end
      cyc(32'h10, 32'h2222_0000, 4'hC, 1'b0, rd, v, d, e);
      cyc(32'h10, 32'h0, 4'h0, 1'b0, rd, v, d, e);
      tests_run++;
      if (rd !== 32'h2222CC11) begin tests_failed++; $display("FAIL lanes_half: got %h want %h", rd, 32'h2222CC11); end
   endtask

   task automatic test_illegal_we();
      logic [31:0] rd; logic v; logic [7:0] d; logic e;
      cyc(32'h10, 32'hFFFF_FFFF, 4'b0101, 1'b0, rd, v, d, e);
      cyc(32'h10, 32'h0, 4'h0, 1'b0, rd, v, d, e);
      tests_run++;
      if (rd !== 32'h2222CC11) begin tests_failed++; $display("FAIL illegal_ram: got %h want %h", rd, 32'h2222CC11); end
      tests_run++;
      if (e !== 1'b1) begin tests_failed++; $display("FAIL illegal_err_set: got %b want 1", e); end
      cyc(A_CLR, 32'h0, 4'hF, 1'b0, rd, v, d, e);
      cyc(A_ST, 32'h0, 4'h0, 1'b0, rd, v, d, e);
      tests_run++;
      if (e !== 1'b0) begin tests_failed++; $display("FAIL errclr: got %b want 0", e); end
      tests_run++;
      if (rd !== 32'h2) begin tests_failed++; $display("FAIL errclr_status: got %h want %h", rd, 32'h2); end
   endtask

   task automatic test_fifo_overflow();
      logic [31:0] rd; logic v; logic [7:0] d; logic e;
      for (int i = 0; i < 5; i++) begin
         cyc(A_TX, 32'h41 + 32'(i), 4'h1, 1'b0, rd, v, d, e);
         if (i < 2) begin
            tests_run++;
            if (v !== (i == 1)) begin tests_failed++; $display("FAIL push_valid_%0d: got %b want %b", i, v, (i == 1)); end
         end
      end
      cyc(A_ST, 32'h0, 4'h0, 1'b0, rd, v, d, e);
      tests_run++;
      if (rd !== 32'h25) begin tests_failed++; $display("FAIL overflow_status: got %h want %h", rd, 32'h25); end
      tests_run++;
      if (e !== 1'b1) begin tests_failed++; $display("FAIL overflow_err: got %b want 1", e); end
      cyc(A_CLR, 32'h0, 4'hF, 1'b0, rd, v, d, e);
      for (int i = 0; i < 4; i++) begin
         cyc(32'h0, 32'h0, 4'h0, 1'b1, rd, v, d, e);
         tests_run++;
         if (v !== 1'b1 || d !== 8'(8'h41 + i)) begin
            tests_failed++;
            $display("FAIL drain_%0d: got valid=%b data=%h want valid=1 data=%h", i, v, d, 8'(8'h41 + i));
         end
      end
      cyc(A_ST, 32'h0, 4'h0, 1'b0, rd, v, d, e);
      tests_run++;
      if (v !== 1'b0 || rd !== 32'h2) begin
         tests_failed++;
         $display("FAIL drained_empty: got valid=%b status=%h want valid=0 status=%h", v, rd, 32'h2);
      end
   endtask

   task automatic test_full_pop();
      logic [31:0] rd; logic v; logic [7:0] d; logic e;
      logic [7:0] exp_b [4] = '{8'h42, 8'h43, 8'h44, 8'h55};
      for (int i = 0; i < 4; i++) cyc(A_TX, 32'h41 + 32'(i), 4'h1, 1'b0, rd, v, d, e);
      cyc(A_TX, 32'h55, 4'h1, 1'b1, rd, v, d, e);
      tests_run++;
      if (v !== 1'b1 || d !== 8'h41) begin tests_failed++; $display("FAIL fullpop_head: got valid=%b data=%h want valid=1 data=41", v, d); end
      for (int i = 0; i < 4; i++) begin
         cyc(32'h0, 32'h0, 4'h0, 1'b1, rd, v, d, e);
         tests_run++;
         if (v !== 1'b1 || d !== exp_b[i] || e !== 1'b0) begin
            tests_failed++;
            $display("FAIL fullpop_drain_%0d: got valid=%b data=%h err=%b want valid=1 data=%h err=0", i, v, d, e, exp_b[i]);
         end
      end
      cyc(A_ST, 32'h0, 4'h0, 1'b0, rd, v, d, e);
      tests_run++;
      if (rd !== 32'h2 || v !== 1'b0) begin tests_failed++; $display("FAIL fullpop_end: got status=%h valid=%b want status=2 valid=0", rd, v); end
   endtask

   task automatic test_counter();
      logic [31:0] rd; logic v; logic [7:0] d; logic e;
      logic [31:0] exp_c [3] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0};
      apply_reset();
      for (int i = 0; i < 10; i++) cyc(32'h0, 32'h0, 4'h0, 1'b0, rd, v, d, e);
      cyc(A_CYCLE, 32'h0, 4'h0, 1'b0, rd, v, d, e);
      tests_run++;
      if (rd !== 32'd10) begin tests_failed++; $display("FAIL cycle_10: got %0d want 10", rd); end
      dut.r_cycle = 32'hFFFF_FFFE;
      m_cycle     = 32'hFFFF_FFFE;
      for (int i = 0; i < 3; i++) begin
         cyc(A_CYCLE, 32'h0, 4'h0, 1'b0, rd, v, d, e);
         tests_run++;
         if (rd !== exp_c[i]) begin tests_failed++; $display("FAIL cycle_wrap_%0d: got %h want %h", i, rd, exp_c[i]); end
      end
   endtask

   task automatic test_async_reset();
      logic [31:0] rd; logic v; logic [7:0] d; logic e;
      for (int i = 0; i < 3; i++) cyc(A_TX, 32'h60 + 32'(i), 4'h1, 1'b0, rd, v, d, e);
      daddr = A_CYCLE; we = 4'h0; tx_ready = 1'b0;
      #1;
      tests_run++;
      if (tx_valid !== 1'b1) begin tests_failed++; $display("FAIL areset_pre_valid: got %b want 1", tx_valid); end
      #1 reset = 1'b0;
      #1;
      tests_run++;
      if (tx_valid !== 1'b0 || drdata !== 32'h0) begin
         tests_failed++;
         $display("FAIL areset_immediate: got valid=%b cycle=%h want valid=0 cycle=0", tx_valid, drdata);
      end
      daddr = 32'h10;
      #1;
      tests_run++;
      if (drdata !== 32'h2222CC11) begin tests_failed++; $display("FAIL areset_ram_kept: got %h want %h", drdata, 32'h2222CC11); end
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      cyc(A_ST, 32'h0, 4'h0, 1'b0, rd, v, d, e);
      tests_run++;
      if (rd !== 32'h2) begin tests_failed++; $display("FAIL areset_status: got %h want %h", rd, 32'h2); end
   endtask

   task automatic test_random();
      logic [31:0] rd; logic v; logic [7:0] d; logic e;
      logic [31:0] a, wd, exp_rd;
      logic [3:0]  w;
      logic        rdy, exp_v, exp_e;
      logic [7:0]  exp_d;
      int          op, idx;
      logic [3:0]  legal [8] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
      logic [3:0]  bad   [8] = '{4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB, 4'hD, 4'hE};
      for (int i = 0; i < 17; i++)
         cyc((i == 16) ? 32'hFFC : 32'(i) * 4, $urandom, 4'hF, 1'b0, rd, v, d, e);
      for (int it = 0; it < 400; it++) begin
         op  = $urandom_range(0, 7);
         rdy = 1'($urandom_range(0, 1));
         idx = ($urandom_range(0, 16) == 16) ? 1023 : $urandom_range(0, 15);
         wd  = $urandom;
         w   = 4'h0;
         a   = 32'(idx) * 4;
         case (op)
            0: w = legal[$urandom_range(1, 7)];
            1: w = 4'h0;
            2: begin a = A_TX; w = ($urandom_range(0, 1) == 1) ? 4'hF : 4'h1; end
            3: a = A_ST;
            4: a = A_CYCLE;
            5: begin a = A_CLR; w = 4'hF; end
            6: begin a = A_UNM + ($urandom & 32'hFFFC); w = legal[$urandom_range(0, 7)]; end
            default: w = bad[$urandom_range(0, 7)];
         endcase
         exp_rd = m_read(a);
         exp_v  = (m_q.size() > 0);
         exp_d  = exp_v ? m_q[0] : 8'h0;
         exp_e  = m_err;
         cyc(a, wd, w, rdy, rd, v, d, e);
         tests_run++;
         if (rd !== exp_rd || v !== exp_v || e !== exp_e || (exp_v && d !== exp_d)) begin
            tests_failed++;
            $display("FAIL random_%0d: addr=%h we=%b got rd=%h valid=%b data=%h err=%b want rd=%h valid=%b data=%h err=%b",
                     it, a, w, rd, v, d, e, exp_rd, exp_v, exp_d, exp_e);
         end
      end
   endtask

   initial begin
      reset = 1'b0; daddr = 32'h0; dwdata = 32'h0; we = 4'h0; tx_ready = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      test_reset();
      test_byte_lanes();
      test_illegal_we();
      test_fifo_overflow();
      test_full_pop();
      test_counter();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Responder end of the CPU data-memory port. It serves `daddr`/`dwdata`/`we`/`drdata` from the single-cycle core with combinational reads and clocked byte-lane writes into word RAM. It also decodes a small MMIO window: a free-running cycle counter, a debug-console TX FIFO drained over a valid/ready handshake, and a sticky error flag. It sits beside the register file and instruction memory in the RV32I top level.

## Interface
- `DEPTH_WORDS`, 1024: RAM size in 32-bit words, power of two.
- `FIFO_DEPTH`, 4: TX FIFO entries, power of two, ≥2.
- `MMIO_BASE`, 32'hFFFF_0000: base address of the 16-byte MMIO window.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `daddr`  in  32  byte address from the core; bits [1:0] ignored for word select.
- `dwdata`  in  32  store data, already lane-aligned by the core.
- `we`  in  4  per-byte write enable; 4'b0000 = read/no store.
- `drdata`  out  32  read data, combinational from `daddr`.
- `tx_data`  out  8  head of TX FIFO.
- `tx_valid`  out  1  FIFO not empty.
- `tx_ready`  in  1  consumer accepts `tx_data` this cycle.
- `err`  out  1  sticky error flag.

## Operation
- Decode on `daddr[31:2]`: RAM if word index < `DEPTH_WORDS`; MMIO if `daddr` in [MMIO_BASE, MMIO_BASE+15]; otherwise unmapped.
- Legal `we`: 0000, 0001, 0010, 0100, 1000, 0011, 1100, 1111. Any other non-zero pattern is illegal: no state change except `err` set.
- RAM write: enabled lanes of `dwdata` written at the edge. RAM contents are not reset.
- MMIO map (word offsets):
  - +0x0 CYCLE: read = counter; writes ignored.
  - +0x4 TXDATA: write with `we[0]`=1 pushes `dwdata[7:0]`; read = 0.
  - +0x8 STATUS: read = {26'b0, count[2:0], err, empty, full}, with `count` saturating at 7; writes ignored.
  - +0xC ERRCLR: any legal write clears `err`; read = 0.
- Unmapped read returns 0. Unmapped legal write is dropped and sets `err`.
- Push to a full FIFO sets `err` and drops the byte, unless a pop occurs in the same cycle. In that case the push is accepted and count stays `FIFO_DEPTH`.
- Pop: occurs when `tx_valid && tx_ready`. Head advances and count decrements.
- Push and pop in the same cycle on a non-empty FIFO: count unchanged, order preserved.
- Push into an empty FIFO: `tx_valid` rises the next cycle. There is no write-through.
- `err` set and ERRCLR in the same cycle: set wins.
- Cycle counter: +1 every clock, wraps 32'hFFFF_FFFF→0.

## Timing
- Reset (asserted low, asynchronous) drives: counter=0; FIFO pointers and count=0; `tx_valid`=0; `err`=0. `tx_data` = the entry at pointer 0 (don't-care while `tx_valid`=0).
- `drdata` is a zero-cycle combinational path from `daddr` and current state. A read reflects pre-edge state: a store and a load to the same word in one cycle cannot occur in a single-cycle core.
- Writes, pushes, pops and `err` updates are effective after the rising edge.
- CYCLE read returns the pre-edge counter value.
- `tx_data` must stay stable while `tx_valid && !tx_ready`.
- Reset mid-operation discards FIFO contents. The consumer must tolerate `tx_valid` dropping without a handshake.

## Structure
- Package `dmem_pkg`:
  - MMIO offset constants: `OFF_CYCLE`, `OFF_TXDATA`, `OFF_STATUS`, `OFF_ERRCLR`.
  - STATUS bit positions.
  - `region_e` enum: RAM, MMIO, UNMAPPED.
  - Function `we_legal(logic [3:0])`.
- Sub-module `tx_fifo`, parameterised by width and depth:
  - Ports: push/din, pop/dout, full, empty, count.
  - Owns pointer wrap and the simultaneous push/pop rule.
- Top level contains: decode, RAM array, counter, error logic, read mux.

## Test plan
- Byte lanes: write 32'hAABBCCDD with we=1111 to addr 0x10, then store 32'h0000_0011 with we=0001 → read of 0x10 returns 32'hAABBCC11. Half store 32'h2222_0000 with we=1100 → 32'h2222CC11.
- Illegal we: we=0101 to 0x10 → RAM unchanged, `err`=1. ERRCLR write → `err`=0 next cycle.
- FIFO: with `tx_ready`=0, push 0x41,0x42,0x43,0x44,0x45 → STATUS full=1, count=4, `err`=1, byte 0x45 lost. Raise `tx_ready` → 0x41..0x44 appear in order, then `tx_valid`=0 and empty=1.
- Full with simultaneous pop: fill 4 entries, then push 0x55 while `tx_ready`=1 → push accepted, `err` stays 0, 0x55 drained last.
- Counter: release reset, read CYCLE after 10 edges → 10. Force counter near wrap (run 2^32 or use a backdoor) → 32'hFFFF_FFFF followed by 0.
- Async reset mid-drain: assert `reset` low between edges with 3 entries queued → `tx_valid`=0 and counter=0 immediately, before the next edge. RAM data previously written still reads back.
